// File: rtl/asip_pkg.sv
// Shared types and constants for the ASIP operand-fetch slice.
// Holds the fetch FSM encoding and register-index geometry.
package asip_pkg;
    localparam int REG_IDX_W = 4;
    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE_A,
        SAMPLE_B,
        CAPT_A,
        CAPT_B,
        OUT
    } fetch_state_t;
endpackage

// File: rtl/operand_capture.sv
// One operand slot: remembers whether the bank was written at the edge it sampled our index,
// then captures either the bank read data or that committed write value (or a direct load).
module operand_capture #(
    parameter int W  = 32,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample,
    input  logic [IW-1:0] index,
    input  logic [IW-1:0] wb_register,
    input  logic [W-1:0]  wb_value,
    input  logic          capture,
    input  logic [W-1:0]  read_value,
    input  logic          load,
    input  logic [W-1:0]  load_value,
    output logic [W-1:0]  value
);
    logic          bypass;
    logic [W-1:0]  held;

    always_ff @(posedge clk) begin
        if (reset) begin
            bypass <= 1'b0;
            held   <= '0;
            value  <= '0;
        end else begin
            // The bank's read port returns pre-write data when write and read share an edge.
            if (sample) begin
                bypass <= (wb_register == index);
                held   <= wb_value;
            end
            if (capture)
                value <= bypass ? held : read_value;
            else if (load)
                value <= load_value;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Serialises source-register reads through the bank's single read port and presents both
// operands to execute; one instruction in flight, held in OUT until execute consumes it.
module operand_fetch
    import asip_pkg::*;
#(
    parameter int RegisterSize      = 32,
    parameter int AmountOfRegisters = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_IDX_W-1:0]    in_rs1,
    input  logic [REG_IDX_W-1:0]    in_rs2,
    input  logic [REG_IDX_W-1:0]    in_rd,
    input  logic                    in_use_imm,
    input  logic [RegisterSize-1:0] in_imm,
    output logic [REG_IDX_W-1:0]    read_register,
    input  logic [RegisterSize-1:0] read_value,
    input  logic [RegisterSize-1:0] pc,
    input  logic [REG_IDX_W-1:0]    wb_register,
    input  logic [RegisterSize-1:0] wb_value,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RegisterSize-1:0] op_a,
    output logic [RegisterSize-1:0] op_b,
    output logic [REG_IDX_W-1:0]    out_rd
);
    fetch_state_t              state, state_next;
    logic [REG_IDX_W-1:0]      rs2_q, rd_q, rr_next;
    logic [RegisterSize-1:0]   imm_q;
    logic                      use_imm_q;
    logic                      sample_a, sample_b, capt_a, capt_b, load_b;
    logic                      unused_ok;

    // pc is observation-only; the bank already returns PC through the read port.
    assign unused_ok = ^{pc, (AmountOfRegisters == (1 << REG_IDX_W))};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_rd    = rd_q;

    always_comb begin
        state_next = state;
        rr_next    = read_register;
        sample_a   = 1'b0;
        sample_b   = 1'b0;
        capt_a     = 1'b0;
        capt_b     = 1'b0;
        load_b     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    rr_next    = in_rs1;
                    state_next = SAMPLE_A;
                end
            end
            SAMPLE_A: begin
                sample_a = 1'b1;
                if (use_imm_q) begin
                    state_next = CAPT_A;
                end else begin
                    rr_next    = rs2_q;
                    state_next = SAMPLE_B;
                end
            end
            SAMPLE_B: begin
                capt_a     = 1'b1;
                sample_b   = 1'b1;
                state_next = CAPT_B;
            end
            CAPT_A: begin
                capt_a     = 1'b1;
                load_b     = 1'b1;
                state_next = OUT;
            end
            CAPT_B: begin
                capt_b     = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            read_register <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            use_imm_q     <= 1'b0;
        end else begin
            state         <= state_next;
            read_register <= rr_next;
            if (state == IDLE && in_valid) begin
                rs2_q     <= in_rs2;
                rd_q      <= in_rd;
                imm_q     <= in_imm;
                use_imm_q <= in_use_imm;
            end
        end
    end

    // read_register still holds the index the bank is sampling, so it doubles as the bypass key.
    operand_capture #(.W(RegisterSize), .IW(REG_IDX_W)) u_cap_a (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample_a),
        .index       (read_register),
        .wb_register (wb_register),
        .wb_value    (wb_value),
        .capture     (capt_a),
        .read_value  (read_value),
        .load        (1'b0),
        .load_value  ({RegisterSize{1'b0}}),
        .value       (op_a)
    );

    operand_capture #(.W(RegisterSize), .IW(REG_IDX_W)) u_cap_b (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample_b),
        .index       (read_register),
        .wb_register (wb_register),
        .wb_value    (wb_value),
        .capture     (capt_b),
        .read_value  (read_value),
        .load        (load_b),
        .load_value  (imm_q),
        .value       (op_b)
    );
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register bank (registered read, write every edge).
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [3:0]  read_register;
    logic [31:0] read_value;
    logic [31:0] pc;
    logic [3:0]  wb_register;
    logic [31:0] wb_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a, op_b;
    logic [3:0]  out_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [16];
    logic [31:0] rdata;

    always #5 clk = ~clk;

    // Bank: index sampled at the edge, data out after it; same-edge write not visible to that read.
    always @(posedge clk) begin
        rdata                <= regs[read_register];
        regs[wb_register]    <= wb_value;
    end
    assign read_value = rdata;
    assign pc         = regs[15];

    operand_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .in_use_imm    (in_use_imm),
        .in_imm        (in_imm),
        .read_register (read_register),
        .read_value    (read_value),
        .pc            (pc),
        .wb_register   (wb_register),
        .wb_value      (wb_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .out_rd        (out_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bank_write(input logic [3:0] idx, input logic [31:0] val);
        wb_register = idx;
        wb_value    = val;
        tick();
        wb_register = 4'd0;
        wb_value    = 32'd0;
    endtask

    // Issue one instruction; optionally commit a bank write at the edge wb_at cycles after accept,
    // and hold out_ready low for 'hold' cycles in OUT while another instruction is offered.
    task automatic issue(input string tag,
                         input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic use_imm, input logic [31:0] imm,
                         input int wb_at, input logic [3:0] wreg, input logic [31:0] wval,
                         input int hold, input int exp_lat,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] erd);
        int n;
        logic saw_rs2;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_use_imm = use_imm; in_imm = imm;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        saw_rs2 = 1'b0;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && n < 12) begin
            if (n == wb_at) begin
                wb_register = wreg; wb_value = wval;
            end else begin
                wb_register = 4'd0; wb_value = 32'd0;
            end
            if (read_register == rs2) saw_rs2 = 1'b1;
            tick();
            n++;
        end
        wb_register = 4'd0; wb_value = 32'd0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_op_a"}, op_a, ea);
        check({tag, "_op_b"}, op_b, eb);
        check({tag, "_out_rd"}, {28'd0, out_rd}, {28'd0, erd});
        if (use_imm && rs2 != rs1) check({tag, "_rs2_not_read"}, {31'd0, saw_rs2}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_rs1 = 4'd7; in_rs2 = 4'd8; in_rd = 4'd1; in_use_imm = 1'b1;
            tick();
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_hold_op_a"}, op_a, ea);
            check({tag, "_hold_op_b"}, op_b, eb);
            check({tag, "_hold_rd"}, {28'd0, out_rd}, {28'd0, erd});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_imm = 1'b0; in_imm = '0; wb_register = '0; wb_value = '0; out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_read_register", {28'd0, read_register}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_out_rd", {28'd0, out_rd}, 32'd0);

        bank_write(4'd1, 32'd5);
        bank_write(4'd2, 32'd7);
        bank_write(4'd4, 32'd9);
        issue("reg_path", 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 0, 4'd0, 32'd0, 0, 4, 32'd5, 32'd7, 4'd3);
        issue("imm_path", 4'd4, 4'd6, 4'd8, 1'b1, 32'hDEAD, 0, 4'd0, 32'd0, 0, 3, 32'd9, 32'hDEAD, 4'd8);
        issue("bypass_a", 4'd1, 4'd2, 4'd5, 1'b0, 32'd0, 1, 4'd1, 32'h55, 0, 4, 32'h55, 32'd7, 4'd5);
        bank_write(4'd1, 32'd5);
        issue("late_wb", 4'd1, 4'd2, 4'd5, 1'b0, 32'd0, 2, 4'd1, 32'h55, 0, 4, 32'd5, 32'd7, 4'd5);
        bank_write(4'd1, 32'd5);
        issue("bypass_b", 4'd2, 4'd2, 4'd4, 1'b0, 32'd0, 2, 4'd2, 32'h77, 0, 4, 32'd7, 32'h77, 4'd4);
        bank_write(4'd2, 32'd7);
        issue("stall", 4'd2, 4'd1, 4'd9, 1'b0, 32'd0, 0, 4'd0, 32'd0, 5, 4, 32'd7, 32'd5, 4'd9);

        // Abort mid-flight in SAMPLE_B.
        in_rs1 = 4'd1; in_rs2 = 4'd2; in_rd = 4'd6; in_use_imm = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("abort_in_sample_b_rr", {28'd0, read_register}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_read_register", {28'd0, read_register}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_op_a", op_a, 32'd0);
        check("abort_out_rd", {28'd0, out_rd}, 32'd0);
        issue("after_abort", 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 0, 4'd0, 32'd0, 0, 4, 32'd5, 32'd7, 4'd3);

        bank_write(4'd15, 32'h100);
        issue("pc_read", 4'd15, 4'd15, 4'd10, 1'b0, 32'd0, 0, 4'd0, 32'd0, 0, 4, 32'h100, 32'h100, 4'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
